// File: rtl/bios_mem_loader_pkg.sv
// Shared definitions for the BIOS RAM frame loader and any host-side frame generator.
// Frame: SYNC | ADDR(4, LE) | LEN(2, LE) | DATA(LEN) | CSUM(XOR of DATA).
package bios_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_ADDR,
    ST_HDR_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_FIN
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         HDR_ADDR_BYTES = 4;
  localparam int         HDR_LEN_BYTES  = 2;

endpackage

// File: rtl/byte_lane_packer.sv
// Collects bytes into their lanes of a 32-bit word, accumulating byte enables.
// Registered, 1 cycle from wr to word/wbe; clr has priority over wr.
module byte_lane_packer
  import bios_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [3:0]  wbe
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= 32'd0;
      wbe  <= 4'd0;
    end else if (wr) begin
      word[{lane, 3'b000} +: 8] <= din;
      wbe[lane]                 <= 1'b1;
    end
  end

endmodule

// File: rtl/bios_mem_loader.sv
// Framed byte stream to byte-enabled 32-bit RAM writes; write strobe 1 cycle after the
// byte completing a word, in_ready drops for that one cycle (and for the done cycle).
module bios_mem_loader
  import bios_mem_loader_pkg::*;
#(
  parameter int         AWIDTH    = 14,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_wen,
  output logic [3:0]        mem_wbe,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              busy,
  output logic              done,
  output logic              csum_err
);

  state_t            state, state_nxt;
  logic [31:0]       byte_addr;
  logic [15:0]       remaining;
  logic [1:0]        hdr_cnt;
  logic [7:0]        csum_acc;
  logic [AWIDTH-1:0] word_addr;
  logic              accept;
  logic              pack_wr, pack_clr;
  logic [31:0]       pack_word;
  logic [3:0]        pack_wbe;
  logic [15:0]       len_full;

  assign in_ready = !rst && (state == ST_IDLE || state == ST_HDR_ADDR || state == ST_HDR_LEN ||
                             state == ST_DATA || state == ST_CSUM);
  assign accept   = in_valid && in_ready;
  assign len_full = {in_data, remaining[7:0]};
  assign mem_addr = word_addr;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pack_wr   = 1'b0;
    pack_clr  = 1'b0;
    mem_wen   = 1'b0;
    mem_wbe   = 4'd0;
    mem_din   = 32'd0;
    done      = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE:     if (accept && in_data == SYNC_BYTE) state_nxt = ST_HDR_ADDR;
      ST_HDR_ADDR: if (accept && hdr_cnt == 2'(HDR_ADDR_BYTES - 1)) state_nxt = ST_HDR_LEN;
      ST_HDR_LEN:  if (accept && hdr_cnt == 2'(HDR_LEN_BYTES - 1))
                     state_nxt = (len_full == 16'd0) ? ST_CSUM : ST_DATA;
      ST_DATA: begin
        if (accept) begin
          pack_wr = 1'b1;
          // Flush on the top lane or on the final byte so partial words still get written.
          if (byte_addr[1:0] == 2'd3 || remaining == 16'd1) state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_wen   = 1'b1;
        mem_wbe   = pack_wbe;
        mem_din   = pack_word;
        pack_clr  = 1'b1;
        state_nxt = (remaining != 16'd0) ? ST_DATA : ST_CSUM;
      end
      ST_CSUM: if (accept) state_nxt = ST_FIN;
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_addr <= 32'd0;
      remaining <= 16'd0;
      hdr_cnt   <= 2'd0;
      csum_acc  <= 8'd0;
      csum_err  <= 1'b0;
      word_addr <= '0;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          if (in_data == SYNC_BYTE) begin
            hdr_cnt  <= 2'd0;
            csum_acc <= 8'd0;
            csum_err <= 1'b0;
          end
        end
        ST_HDR_ADDR: begin
          byte_addr[{hdr_cnt, 3'b000} +: 8] <= in_data;
          hdr_cnt <= hdr_cnt + 2'd1;
        end
        ST_HDR_LEN: begin
          remaining[{hdr_cnt[0], 3'b000} +: 8] <= in_data;
          hdr_cnt <= (hdr_cnt == 2'(HDR_LEN_BYTES - 1)) ? 2'd0 : hdr_cnt + 2'd1;
        end
        ST_DATA: begin
          csum_acc  <= csum_acc ^ in_data;
          byte_addr <= byte_addr + 32'd1;
          remaining <= remaining - 16'd1;
          word_addr <= byte_addr[AWIDTH+1:2];
        end
        ST_CSUM: csum_err <= (in_data != csum_acc);
        default: ;
      endcase
    end
  end

  byte_lane_packer u_packer (
    .clk  (clk),
    .rst  (rst),
    .clr  (pack_clr),
    .wr   (pack_wr),
    .lane (byte_addr[1:0]),
    .din  (in_data),
    .word (pack_word),
    .wbe  (pack_wbe)
  );

endmodule

// File: tb/tb_bios_mem_loader.sv
// Bench for bios_mem_loader: directed vector table, reset-abort sequence, random frames vs. a word-grouping model.
module tb_bios_mem_loader;
  import bios_mem_loader_pkg::*;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready, mem_wen, busy, done, csum_err;
  logic [3:0]    mem_wbe;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bios_mem_loader #(.AWIDTH(AW), .SYNC_BYTE(SYNC_BYTE_DEF)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_wen(mem_wen), .mem_wbe(mem_wbe), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .done(done), .csum_err(csum_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [3:0]    wbe;
  } wr_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] dat;
    int          len;
    bit          use_cs;
    logic [7:0]  cs_val;
    int          gap;
    int          garbage;
    int          nwr;
    wr_t         w0;
    wr_t         w1;
    bit          err;
  } vec_t;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic       done_q[$];
  logic [7:0] fdata[$];
  vec_t       vt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mem_wen) begin
      got_q.push_back('{mem_addr, mem_din, mem_wbe});
      chk("rdy_in_write", 64'(in_ready), 64'd0);
    end
    if (!rst && done) begin
      done_q.push_back(csum_err);
      chk("busy_at_done", 64'(busy), 64'd1);
    end
  end

  function automatic vec_t mkv(input logic [31:0] a, input logic [63:0] d, input int n, input bit uc,
                               input logic [7:0] cv, input int g, input int gb, input int nw,
                               input wr_t x0, input wr_t x1, input bit e);
    vec_t v;
    v.addr = a; v.dat = d; v.len = n; v.use_cs = uc; v.cs_val = cv; v.gap = g; v.garbage = gb;
    v.nwr = nw; v.w0 = x0; v.w1 = x1; v.err = e;
    return v;
  endfunction

  function automatic logic [7:0] xor_q();
    logic [7:0] x;
    x = 8'd0;
    foreach (fdata[i]) x ^= fdata[i];
    return x;
  endfunction

  // Reference: consecutive stream bytes sharing one word address form one write.
  function automatic void build_expect(input logic [31:0] addr);
    logic [31:0] ba, cur_w;
    wr_t         e;
    bit          open;
    open = 0; cur_w = 0; e = '0;
    exp_q.delete();
    foreach (fdata[i]) begin
      ba = addr + 32'(i);
      if (open && (ba >> 2) != cur_w) begin
        exp_q.push_back(e);
        open = 0;
      end
      if (!open) begin
        cur_w = ba >> 2;
        e.addr = AW'(cur_w % (32'd1 << AW));
        e.din = 32'd0; e.wbe = 4'd0;
        open = 1;
      end
      e.din[8*ba[1:0] +: 8] = fdata[i];
      e.wbe[ba[1:0]] = 1'b1;
    end
    if (open) exp_q.push_back(e);
  endfunction

  task automatic push(input logic [7:0] b, input int gap);
    if (gap > 0 && int'($urandom_range(99)) < gap) repeat ($urandom_range(3, 1)) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (in_ready) begin
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_header(input logic [31:0] addr, input int gap);
    int n;
    n = fdata.size();
    push(SYNC_BYTE_DEF, gap);
    for (int i = 0; i < HDR_ADDR_BYTES; i++) push(addr[8*i +: 8], gap);
    push(n[7:0], gap);
    push(n[15:8], gap);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] addr, input logic [7:0] cs,
                           input int gap, input int garbage);
    logic exp_err;
    got_q.delete();
    done_q.delete();
    build_expect(addr);
    exp_err = (cs != xor_q());
    for (int k = 0; k < garbage; k++) push(k[0] ? 8'hFF : 8'h00, 0);
    send_header(addr, gap);
    foreach (fdata[i]) push(fdata[i], gap);
    push(cs, gap);
    for (int t = 0; t < 20 && done_q.size() == 0; t++) @(negedge clk);
    @(negedge clk);
    chk({tag, "_done_cnt"}, 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) chk({tag, "_csum_err"}, 64'(done_q[0]), 64'(exp_err));
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_write%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    logic [7:0]  cs;
    logic [31:0] a;
    int          n;
    vec_t        v;

    vt[0] = mkv(32'h10, 64'h8877665544332211, 8, 0, 8'h00, 0, 0, 2,
                wr_t'{14'h4, 32'h44332211, 4'hF}, wr_t'{14'h5, 32'h88776655, 4'hF}, 0);
    vt[1] = mkv(32'h3, 64'h0000000000CCBBAA, 3, 0, 8'h00, 0, 0, 2,
                wr_t'{14'h0, 32'hAA000000, 4'h8}, wr_t'{14'h1, 32'h0000CCBB, 4'h3}, 0);
    vt[2] = mkv(32'h10, 64'h8877665544332211, 8, 1, 8'h00, 0, 0, 2,
                wr_t'{14'h4, 32'h44332211, 4'hF}, wr_t'{14'h5, 32'h88776655, 4'hF}, 1);
    vt[3] = mkv(32'h0, 64'h0, 0, 0, 8'h00, 0, 2, 0, '0, '0, 0);
    vt[4] = mkv(32'h10, 64'h8877665544332211, 8, 0, 8'h00, 50, 0, 2,
                wr_t'{14'h4, 32'h44332211, 4'hF}, wr_t'{14'h5, 32'h88776655, 4'hF}, 0);
    vt[5] = mkv(32'h0000FFFC, 64'h04030201, 4, 0, 8'h00, 0, 0, 1,
                wr_t'{14'h3FFF, 32'h04030201, 4'hF}, '0, 0);
    vt[6] = mkv(32'hFFFFFFFE, 64'h04030201, 4, 0, 8'h00, 0, 0, 2,
                wr_t'{14'h3FFF, 32'h02010000, 4'hC}, wr_t'{14'h0, 32'h00000403, 4'h3}, 0);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_mem_wbe", 64'(mem_wbe), 64'd0);
    chk("rst_mem_din", 64'(mem_din), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_csum_err", 64'(csum_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    for (int k = 0; k < 7; k++) begin
      v = vt[k];
      fdata.delete();
      for (int i = 0; i < v.len; i++) fdata.push_back(v.dat[8*i +: 8]);
      cs = v.use_cs ? v.cs_val : xor_q();
      run_frame($sformatf("vec%0d", k), v.addr, cs, v.gap, v.garbage);
      chk($sformatf("vec%0d_tbl_nwr", k), 64'(got_q.size()), 64'(v.nwr));
      if (v.nwr > 0 && got_q.size() > 0) chk($sformatf("vec%0d_tbl_w0", k), 64'(got_q[0]), 64'(v.w0));
      if (v.nwr > 1 && got_q.size() > 1) chk($sformatf("vec%0d_tbl_w1", k), 64'(got_q[1]), 64'(v.w1));
      if (done_q.size() > 0) chk($sformatf("vec%0d_tbl_err", k), 64'(done_q[0]), 64'(v.err));
    end

    // Reset after 5 data bytes: only the first full word may reach the RAM.
    got_q.delete();
    done_q.delete();
    fdata.delete();
    for (int i = 1; i <= 8; i++) fdata.push_back(8'(i * 8'h11));
    send_header(32'h10, 0);
    for (int i = 0; i < 5; i++) push(fdata[i], 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_nwr", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("abort_w0", 64'(got_q[0]), 64'(wr_t'{14'h4, 32'h44332211, 4'hF}));
    chk("abort_no_done", 64'(done_q.size()), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);

    for (int f = 0; f < 30; f++) begin
      a = ($urandom_range(1) == 1) ? $urandom() : 32'hFFFF_FFF0 + 32'($urandom_range(15));
      n = int'($urandom_range(20));
      fdata.delete();
      for (int i = 0; i < n; i++) fdata.push_back(8'($urandom_range(255)));
      cs = xor_q();
      if ($urandom_range(3) == 0) cs ^= 8'($urandom_range(255, 1));
      run_frame($sformatf("rnd%0d", f), a, cs, ($urandom_range(1) == 1) ? 40 : 0, int'($urandom_range(2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
